cam_config_sequencer: RTL

- Walks a camera register-initialisation table and issues one SCCB register write per entry to the downstream SCCB master (sccb_interface) over its start/address/data/ready handshake.
- Sits between the system start/control logic and the SCCB master.
- Supports delay entries, an end marker and a handshake timeout.
- Asserts config_done once the camera is configured so the capture pipeline may start.

---
 rtl/cam_config_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/cam_config_sequencer.sv
// cam_config_sequencer: walks a camera register table and issues one SCCB write per entry,
// honouring delay entries, an end marker, forbidden read-address entries and a busy timeout.
module cam_config_sequencer #(
  parameter int ROM_AW       = 8,
  parameter int CLK_FREQ     = 25000000,
  parameter int DELAY_MS     = 10,
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              config_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              sccb_ready,
  output logic              sccb_start,
  output logic [7:0]        sccb_address,
  output logic [7:0]        sccb_data,
  output logic              busy,
  output logic              config_done,
  output logic              config_error
);
  typedef enum logic [3:0] {IDLE, FETCH, READ, DECODE, SEND, WAIT_BUSY, WAIT_DONE, DELAY, DONE} state_t;
  localparam logic [31:0] DELAY_TICKS = 32'(DELAY_MS * (CLK_FREQ / 1000));
  localparam logic [31:0] BUSY_TICKS  = 32'(BUSY_TIMEOUT);
  state_t            state, state_d;
  logic [ROM_AW-1:0] addr_d;
  logic [15:0]       entry, entry_d;
  logic [7:0]        adr_d, dat_d;
  logic              start_d, err_d, adv;
  logic [31:0]       cnt, cnt_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      rom_addr     <= '0;
      entry        <= '0;
      sccb_address <= '0;
      sccb_data    <= '0;
      sccb_start   <= 1'b0;
      config_error <= 1'b0;
      cnt          <= '0;
    end else if (clk_en) begin
      state        <= state_d;
      rom_addr     <= addr_d;
      entry        <= entry_d;
      sccb_address <= adr_d;
      sccb_data    <= dat_d;
      sccb_start   <= start_d;
      config_error <= err_d;
      cnt          <= cnt_d;
    end
  always_comb begin
    state_d = state;
    addr_d  = rom_addr;
    entry_d = entry;
    adr_d   = sccb_address;
    dat_d   = sccb_data;
    start_d = 1'b0;
    err_d   = config_error;
    cnt_d   = cnt;
    adv     = 1'b0;
    case (state)
      IDLE, DONE: if (config_start) begin
        addr_d  = '0;
        err_d   = 1'b0;
        state_d = FETCH;
      end
      FETCH: state_d = READ;
      READ: begin
        entry_d = rom_data;
        state_d = DECODE;
      end
      DECODE:
        if (entry == 16'hFFFF) state_d = DONE;
        else if (entry == 16'hFFF0) begin
          cnt_d   = DELAY_TICKS;
          state_d = DELAY;
        end else if (entry[15:8] == 8'hFE) adv = 1'b1;
        else begin
          adr_d   = entry[15:8];
          dat_d   = entry[7:0];
          state_d = SEND;
        end
      SEND: if (sccb_ready) begin
        start_d = 1'b1;
        cnt_d   = BUSY_TICKS;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY:
        if (!sccb_ready) state_d = WAIT_DONE;
        else if (cnt <= 32'd1) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else cnt_d = cnt - 32'd1;
      WAIT_DONE: adv = sccb_ready;
      DELAY: begin
        adv   = cnt <= 32'd1;
        cnt_d = cnt == 32'd0 ? cnt : cnt - 32'd1;
      end
      default: state_d = IDLE;
    endcase
    // rom_addr saturates at the last entry; running off the table is an error
    if (adv) begin
      err_d   = err_d | (&rom_addr);
      state_d = &rom_addr ? DONE : FETCH;
      addr_d  = &rom_addr ? rom_addr : rom_addr + ROM_AW'(1);
    end
  end
  assign busy        = !(state == IDLE || state == DONE);
  assign config_done = state == DONE;
endmodule
